ripple_count_ctrl: RTL and testbench

Synchronous sequencer for the D-flip-flop ripple counter.
- Clears the counter, issues a programmed number of count pulses, and waits a settle window after every pulse before sampling the counter's asynchronous outputs.
- Checks each sampled value against an internal expected count.
- Reports done, the final count, and a sticky error if the ripple chain mis-counts.
- Sits between a host start/target interface and the ripple counter's clk/clr inputs.

---
 rtl/ripple_count_ctrl_pkg.sv | 21 ++
 rtl/ripple_count_ctrl_settle_timer.sv | 30 +++
 rtl/ripple_count_ctrl.sv | 127 ++++++++++++
 tb/tb_ripple_count_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ripple_count_ctrl_pkg.sv
// Shared types and defaults for the ripple counter sequencer.
// The state enum is reused by the top-level FSM and by the bench.
package ripple_count_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        PULSE,
        LOW,
        WAIT,
        SAMPLE,
        DONE,
        ABORT
    } state_t;

    localparam int DEF_WIDTH  = 4;
    localparam int DEF_SETTLE = 2;
    // Settle windows are limited to 1..15 cycles, so four bits suffice.
    localparam int SETTLE_W   = 4;

endpackage

// File: rtl/ripple_count_ctrl_settle_timer.sv
// Loadable down-counter that times the settle window after a clear or a pulse.
// o_expire marks the last cycle of the window.
module ripple_count_ctrl_settle_timer
    import ripple_count_ctrl_pkg::*;
#(
    parameter int W = SETTLE_W
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_dec,
    output logic         o_expire
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_expire = (r_count == {{(W-1){1'b0}}, 1'b1});

endmodule

// File: rtl/ripple_count_ctrl.sv
// Sequencer for an asynchronous D-FF ripple counter: clear, pulse, settle, sample, compare.
// All outputs are registered decodes of the current state, so they trail the state by one cycle.
module ripple_count_ctrl
    import ripple_count_ctrl_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int SETTLE = DEF_SETTLE
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] target,
    input  logic [WIDTH-1:0] cnt_q,
    output logic             cnt_tick,
    output logic             cnt_clr,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [WIDTH-1:0] count_out
);

    localparam logic [SETTLE_W-1:0] SETTLE_V = SETTLE_W'(SETTLE);

    state_t           r_state;
    state_t           w_state_nx;
    logic             w_load;
    logic             w_dec;
    logic             w_expire;
    logic             w_abort_req;
    logic [WIDTH-1:0] r_tgt;
    logic [WIDTH-1:0] r_exp;
    logic             r_cnt_tick;
    logic             r_cnt_clr;
    logic             r_busy;
    logic             r_done;
    logic             r_error;
    logic [WIDTH-1:0] r_count_out;

    ripple_count_ctrl_settle_timer #(.W(SETTLE_W)) u_settle_timer (
        .clk        (clk),
        .clr        (clr),
        .i_load     (w_load),
        .i_load_val (SETTLE_V),
        .i_dec      (w_dec),
        .o_expire   (w_expire)
    );

    // ABORT is already the teardown, so a held abort does not stretch it.
    assign w_abort_req = abort && (r_state != IDLE) && (r_state != ABORT);

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) r_state <= IDLE;
        else      r_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx = r_state;
        w_load     = 1'b0;
        w_dec      = 1'b0;
        if (w_abort_req) begin
            w_state_nx = ABORT;
        end else begin
            case (r_state)
                IDLE:    if (start) w_state_nx = CLEAR;
                CLEAR: begin
                    w_load     = 1'b1;
                    w_state_nx = WAIT;
                end
                PULSE:   w_state_nx = LOW;
                LOW: begin
                    w_load     = 1'b1;
                    w_state_nx = WAIT;
                end
                WAIT: begin
                    w_dec = 1'b1;
                    if (w_expire) w_state_nx = SAMPLE;
                end
                SAMPLE: begin
                    if (cnt_q != r_exp)      w_state_nx = IDLE;
                    else if (cnt_q == r_tgt) w_state_nx = DONE;
                    else                     w_state_nx = PULSE;
                end
                DONE:    w_state_nx = IDLE;
                ABORT:   w_state_nx = IDLE;
                default: w_state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_cnt_tick  <= 1'b0;
            r_cnt_clr   <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
            r_count_out <= '0;
            r_tgt       <= '0;
            r_exp       <= '0;
        end else begin
            r_cnt_tick <= (r_state == PULSE);
            r_cnt_clr  <= (r_state == CLEAR) || (r_state == ABORT);
            r_busy     <= (r_state != IDLE);
            r_done     <= (r_state == DONE) && !w_abort_req;
            if ((r_state == IDLE) && start) begin
                r_tgt   <= target;
                r_error <= 1'b0;
            end
            if (r_state == CLEAR) r_exp <= '0;
            if (r_state == PULSE) r_exp <= r_exp + 1'b1;
            // An abort landing on SAMPLE discards that sample entirely.
            if ((r_state == SAMPLE) && !w_abort_req) begin
                r_count_out <= cnt_q;
                if (cnt_q != r_exp) r_error <= 1'b1;
            end
        end
    end

    assign cnt_tick  = r_cnt_tick;
    assign cnt_clr   = r_cnt_clr;
    assign busy      = r_busy;
    assign done      = r_done;
    assign error     = r_error;
    assign count_out = r_count_out;

endmodule

// File: tb/tb_ripple_count_ctrl.sv
// Bench for ripple_count_ctrl driving a behavioural ripple counter with an optional skip fault.
// Cycle n is counted from the edge that accepts start (n=0 is the cycle after that edge).
module tb_ripple_count_ctrl;
    import ripple_count_ctrl_pkg::*;

    localparam int WIDTH  = 4;
    localparam int SETTLE = 2;

    logic             clk = 1'b0;
    logic             clr;
    logic             start;
    logic             abort;
    logic [WIDTH-1:0] target;
    logic [WIDTH-1:0] cnt_q;
    logic             cnt_tick;
    logic             cnt_clr;
    logic             busy;
    logic             done;
    logic             error;
    logic [WIDTH-1:0] count_out;

    always #5 clk = ~clk;

    ripple_count_ctrl #(.WIDTH(WIDTH), .SETTLE(SETTLE)) dut (
        .clk       (clk),
        .clr       (clr),
        .start     (start),
        .abort     (abort),
        .target    (target),
        .cnt_q     (cnt_q),
        .cnt_tick  (cnt_tick),
        .cnt_clr   (cnt_clr),
        .busy      (busy),
        .done      (done),
        .error     (error),
        .count_out (count_out)
    );

    // Behavioural ripple counter; skip_en makes the second pulse advance by two.
    logic             skip_en = 1'b0;
    int               pulse_cnt = 0;
    logic [WIDTH-1:0] model_q = '0;

    always @(posedge cnt_tick or posedge cnt_clr) begin
        if (cnt_clr) begin
            model_q   <= '0;
            pulse_cnt <= 0;
        end else begin
            pulse_cnt <= pulse_cnt + 1;
            model_q   <= model_q + ((skip_en && pulse_cnt == 1) ? 4'd2 : 4'd1);
        end
    end
    assign cnt_q = model_q;

    typedef struct {
        int               done_n;
        int               end_n;
        int               ticks;
        logic [WIDTH-1:0] count;
        logic             err;
    } exp_t;

    typedef struct {
        int               done_n;
        int               done_cnt;
        int               ticks;
        int               clr_cnt;
        int               clr_first;
        int               clr_last;
        int               end_n;
        logic             err0;
        logic             err_end;
        logic             bad_tick;
        logic [WIDTH-1:0] cnt_end;
    } res_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic int done_cycle(input int t);
        return 3 + SETTLE + t * (SETTLE + 3);
    endfunction

    // Issues start with tgt, optionally injects a second start and an abort, and
    // records what the outputs did until busy falls (or the budget runs out).
    task automatic run(input logic [WIDTH-1:0] tgt, input int inj_start_n,
                       input logic [WIDTH-1:0] inj_tgt, input int abort_n,
                       output res_t r);
        logic prev_tick;
        @(negedge clk);
        start  = 1'b1;
        target = tgt;
        @(negedge clk);
        start  = 1'b0;
        target = '0;
        r.done_n = -1; r.done_cnt = 0; r.ticks = 0; r.clr_cnt = 0;
        r.clr_first = -1; r.clr_last = -1; r.end_n = -1;
        r.err0 = error; r.err_end = 1'b0; r.bad_tick = 1'b0; r.cnt_end = '0;
        prev_tick = 1'b0;
        for (int n = 0; n < 200; n++) begin
            if (n > 0) @(negedge clk);
            if (done) begin r.done_n = n; r.done_cnt++; end
            if (cnt_tick && !prev_tick) r.ticks++;
            if (cnt_tick && (cnt_clr || prev_tick)) r.bad_tick = 1'b1;
            prev_tick = cnt_tick;
            if (cnt_clr) begin
                r.clr_cnt++;
                r.clr_last = n;
                if (r.clr_first < 0) r.clr_first = n;
            end
            if (n >= 2 && !busy) begin
                r.end_n   = n;
                r.err_end = error;
                r.cnt_end = count_out;
                break;
            end
            start = (n == inj_start_n);
            if (start) target = inj_tgt;
            abort = (n == abort_n);
        end
        start = 1'b0;
        abort = 1'b0;
    endtask

    task automatic test_reset();
        clr = 1'b0; start = 1'b0; abort = 1'b0; target = '0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({cnt_tick, cnt_clr, busy, done, error, count_out} !== '0) begin
            n_bad++;
            $display("FAIL reset_outs: got %b want 0", {cnt_tick, cnt_clr, busy, done, error, count_out});
        end
        clr = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_target0();
        res_t r;
        exp_t e;
        sb_q.push_back('{done_cycle(0), done_cycle(0) + 1, 0, 4'd0, 1'b0});
        run(4'd0, -1, '0, -1, r);
        e = sb_q.pop_front();
        n_cmp++;
        if (r.end_n !== e.end_n) begin n_bad++; $display("FAIL t0_end: got %0d want %0d", r.end_n, e.end_n); end
        n_cmp++;
        if (r.done_n !== e.done_n) begin n_bad++; $display("FAIL t0_done: got %0d want %0d", r.done_n, e.done_n); end
        n_cmp++;
        if (r.ticks !== e.ticks) begin n_bad++; $display("FAIL t0_ticks: got %0d want %0d", r.ticks, e.ticks); end
        n_cmp++;
        if (r.clr_first !== 1 || r.clr_cnt !== 1) begin
            n_bad++; $display("FAIL t0_clr: first %0d cnt %0d want 1 1", r.clr_first, r.clr_cnt);
        end
        n_cmp++;
        if (r.cnt_end !== e.count) begin n_bad++; $display("FAIL t0_count: got %0d want %0d", r.cnt_end, e.count); end
    endtask

    task automatic test_target3_busy_start();
        res_t r;
        exp_t e;
        sb_q.push_back('{done_cycle(3), done_cycle(3) + 1, 3, 4'd3, 1'b0});
        run(4'd3, 6, 4'd1, -1, r);
        e = sb_q.pop_front();
        n_cmp++;
        if (r.done_n !== e.done_n || r.done_cnt !== 1) begin
            n_bad++; $display("FAIL t3_done: got %0d x%0d want %0d x1", r.done_n, r.done_cnt, e.done_n);
        end
        n_cmp++;
        if (r.ticks !== e.ticks) begin n_bad++; $display("FAIL t3_ticks: got %0d want %0d", r.ticks, e.ticks); end
        n_cmp++;
        if (r.bad_tick !== 1'b0) begin n_bad++; $display("FAIL t3_tick_shape: got %b want 0", r.bad_tick); end
        n_cmp++;
        if (r.cnt_end !== e.count || r.err_end !== e.err) begin
            n_bad++; $display("FAIL t3_result: count %0d err %b want %0d %b", r.cnt_end, r.err_end, e.count, e.err);
        end
        n_cmp++;
        if (r.clr_cnt !== 1) begin n_bad++; $display("FAIL t3_clr_cnt: got %0d want 1", r.clr_cnt); end
    endtask

    task automatic test_target15();
        res_t r;
        exp_t e;
        sb_q.push_back('{done_cycle(15), done_cycle(15) + 1, 15, 4'd15, 1'b0});
        run(4'd15, -1, '0, -1, r);
        e = sb_q.pop_front();
        n_cmp++;
        if (r.done_n !== e.done_n) begin n_bad++; $display("FAIL t15_done: got %0d want %0d", r.done_n, e.done_n); end
        n_cmp++;
        if (r.ticks !== e.ticks || r.bad_tick !== 1'b0) begin
            n_bad++; $display("FAIL t15_ticks: got %0d bad %b want %0d 0", r.ticks, r.bad_tick, e.ticks);
        end
        n_cmp++;
        if (r.cnt_end !== e.count || r.err_end !== e.err) begin
            n_bad++; $display("FAIL t15_result: count %0d err %b want %0d %b", r.cnt_end, r.err_end, e.count, e.err);
        end
    endtask

    task automatic test_skip_error();
        res_t r;
        exp_t e;
        // Second sample (cycle 13) sees 3 instead of 2; error lands at 14, busy drops at 15.
        skip_en = 1'b1;
        sb_q.push_back('{-1, 3 + 2 * (SETTLE + 3) + 2, 2, 4'd3, 1'b1});
        run(4'd5, -1, '0, -1, r);
        skip_en = 1'b0;
        e = sb_q.pop_front();
        n_cmp++;
        if (r.done_cnt !== 0) begin n_bad++; $display("FAIL skip_no_done: got %0d want 0", r.done_cnt); end
        n_cmp++;
        if (r.end_n !== e.end_n) begin n_bad++; $display("FAIL skip_end: got %0d want %0d", r.end_n, e.end_n); end
        n_cmp++;
        if (r.err_end !== e.err || r.cnt_end !== e.count) begin
            n_bad++; $display("FAIL skip_result: err %b count %0d want %b %0d", r.err_end, r.cnt_end, e.err, e.count);
        end
        sb_q.push_back('{done_cycle(2), done_cycle(2) + 1, 2, 4'd2, 1'b0});
        run(4'd2, -1, '0, -1, r);
        e = sb_q.pop_front();
        n_cmp++;
        if (r.err0 !== 1'b0) begin n_bad++; $display("FAIL skip_err_clear: got %b want 0", r.err0); end
        n_cmp++;
        if (r.done_n !== e.done_n || r.cnt_end !== e.count || r.err_end !== e.err) begin
            n_bad++; $display("FAIL skip_rerun: done %0d count %0d err %b want %0d %0d %b",
                              r.done_n, r.cnt_end, r.err_end, e.done_n, e.count, e.err);
        end
    endtask

    task automatic test_abort();
        res_t r;
        exp_t e;
        // Third WAIT occupies cycles 11-12; abort sampled at edge 12, cnt_clr at 13, idle by 14.
        sb_q.push_back('{-1, 14, 2, 4'd1, 1'b0});
        run(4'd5, 5, 4'd1, 11, r);
        e = sb_q.pop_front();
        n_cmp++;
        if (r.done_cnt !== 0) begin n_bad++; $display("FAIL abort_no_done: got %0d want 0", r.done_cnt); end
        n_cmp++;
        if (r.clr_cnt !== 2 || r.clr_last !== 13) begin
            n_bad++; $display("FAIL abort_clr: cnt %0d last %0d want 2 13", r.clr_cnt, r.clr_last);
        end
        n_cmp++;
        if (r.end_n !== e.end_n || r.ticks !== e.ticks) begin
            n_bad++; $display("FAIL abort_end: end %0d ticks %0d want %0d %0d", r.end_n, r.ticks, e.end_n, e.ticks);
        end
        n_cmp++;
        if (r.cnt_end !== e.count || r.err_end !== e.err) begin
            n_bad++; $display("FAIL abort_hold: count %0d err %b want %0d %b", r.cnt_end, r.err_end, e.count, e.err);
        end
        sb_q.push_back('{done_cycle(4), done_cycle(4) + 1, 4, 4'd4, 1'b0});
        run(4'd4, -1, '0, -1, r);
        e = sb_q.pop_front();
        n_cmp++;
        if (r.done_n !== e.done_n || r.cnt_end !== e.count || r.ticks !== e.ticks) begin
            n_bad++; $display("FAIL abort_rerun: done %0d count %0d ticks %0d want %0d %0d %0d",
                              r.done_n, r.cnt_end, r.ticks, e.done_n, e.count, e.ticks);
        end
    endtask

    task automatic test_reset_midrun();
        res_t r;
        exp_t e;
        @(negedge clk);
        start  = 1'b1;
        target = 4'd3;
        @(negedge clk);
        start  = 1'b0;
        repeat (12) @(negedge clk);
        // Cycle 12: second WAIT after the first pulse, count_out already holds 1.
        n_cmp++;
        if (busy !== 1'b1 || count_out !== 4'd1) begin
            n_bad++; $display("FAIL midrun_pre: busy %b count %0d want 1 1", busy, count_out);
        end
        clr = 1'b0;
        #1;
        n_cmp++;
        if ({cnt_tick, cnt_clr, busy, done, error, count_out} !== '0) begin
            n_bad++; $display("FAIL midrun_reset: got %b want 0", {cnt_tick, cnt_clr, busy, done, error, count_out});
        end
        @(negedge clk);
        clr = 1'b1;
        sb_q.push_back('{done_cycle(1), done_cycle(1) + 1, 1, 4'd1, 1'b0});
        run(4'd1, -1, '0, -1, r);
        e = sb_q.pop_front();
        n_cmp++;
        if (r.done_n !== e.done_n || r.cnt_end !== e.count || r.err_end !== e.err) begin
            n_bad++; $display("FAIL midrun_rerun: done %0d count %0d err %b want %0d %0d %b",
                              r.done_n, r.cnt_end, r.err_end, e.done_n, e.count, e.err);
        end
    endtask

    initial begin
        test_reset();
        test_target0();
        test_target3_busy_start();
        test_target15();
        test_skip_error();
        test_abort();
        test_reset_midrun();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
